// File: rtl/coffee_dispenser.sv
// Dispense-side responder: accepts a held dispense request, sequences cup drop,
// water pour and optional flavour pour, then pulses dispense_done once per cup.
module coffee_dispenser #(
  parameter int CUP_CYCLES    = 4,
  parameter int POUR_CYCLES   = 8,
  parameter int FLAVOR_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispense,
  input  logic [2:0]       coffee_select,
  input  logic             cup_empty,
  output logic             cup_drop,
  output logic             water_valve,
  output logic [1:0]       flavor_valve,
  output logic             dispense_done,
  output logic             busy,
  output logic             fault,
  output logic             sel_err,
  output logic [CNT_W-1:0] cups_served
);

  localparam int MAX_A   = (CUP_CYCLES > POUR_CYCLES) ? CUP_CYCLES : POUR_CYCLES;
  localparam int MAX_PH  = (MAX_A > FLAVOR_CYCLES) ? MAX_A : FLAVOR_CYCLES;
  localparam int PH_W    = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  localparam logic [PH_W-1:0] CUP_LOAD    = PH_W'(CUP_CYCLES - 1);
  localparam logic [PH_W-1:0] POUR_LOAD   = PH_W'(POUR_CYCLES - 1);
  localparam logic [PH_W-1:0] FLAVOR_LOAD = PH_W'(FLAVOR_CYCLES - 1);
  localparam logic [1:0]      SEL_PLAIN   = 2'b01;

  typedef enum logic [2:0] {
    IDLE, CUP, POUR, FLAVOR, DONE, RELEASE, FAULT
  } state_t;

  state_t            state_reg;
  logic [PH_W-1:0]   phase_cnt_reg;
  logic [1:0]        sel_reg;
  logic              cup_drop_reg;
  logic              water_valve_reg;
  logic [1:0]        flavor_valve_reg;
  logic              dispense_done_reg;
  logic              busy_reg;
  logic              fault_reg;
  logic              sel_err_reg;
  logic [CNT_W-1:0]  cups_served_reg;
  logic [CNT_W-1:0]  cups_next;

  // Bit 2 of the select carries no meaning for the mechanism.
  logic sel_bit2_unused;
  assign sel_bit2_unused = coffee_select[2];

  assign cups_next = (cups_served_reg == {CNT_W{1'b1}}) ? cups_served_reg
                                                        : cups_served_reg + CNT_W'(1);

  // Outputs are assigned alongside each transition so they reflect the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      phase_cnt_reg     <= '0;
      sel_reg           <= 2'b00;
      cup_drop_reg      <= 1'b0;
      water_valve_reg   <= 1'b0;
      flavor_valve_reg  <= 2'b00;
      dispense_done_reg <= 1'b0;
      busy_reg          <= 1'b0;
      fault_reg         <= 1'b0;
      sel_err_reg       <= 1'b0;
      cups_served_reg   <= '0;
    end else begin
      cup_drop_reg      <= 1'b0;
      water_valve_reg   <= 1'b0;
      flavor_valve_reg  <= 2'b00;
      dispense_done_reg <= 1'b0;
      sel_err_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (dispense) begin
            if (cup_empty) begin
              state_reg <= FAULT;
              fault_reg <= 1'b1;
              busy_reg  <= 1'b0;
            end else if (coffee_select[1:0] == 2'b00) begin
              sel_err_reg <= 1'b1;
            end else begin
              sel_reg       <= coffee_select[1:0];
              state_reg     <= CUP;
              cup_drop_reg  <= 1'b1;
              busy_reg      <= 1'b1;
              phase_cnt_reg <= CUP_LOAD;
            end
          end
        end
        CUP: begin
          if (phase_cnt_reg == '0) begin
            state_reg       <= POUR;
            water_valve_reg <= 1'b1;
            phase_cnt_reg   <= POUR_LOAD;
          end else begin
            cup_drop_reg  <= 1'b1;
            phase_cnt_reg <= phase_cnt_reg - 1'b1;
          end
        end
        POUR: begin
          if (phase_cnt_reg == '0) begin
            if (sel_reg == SEL_PLAIN) begin
              state_reg         <= DONE;
              dispense_done_reg <= 1'b1;
              cups_served_reg   <= cups_next;
            end else begin
              state_reg        <= FLAVOR;
              flavor_valve_reg <= sel_reg;
              phase_cnt_reg    <= FLAVOR_LOAD;
            end
          end else begin
            water_valve_reg <= 1'b1;
            phase_cnt_reg   <= phase_cnt_reg - 1'b1;
          end
        end
        FLAVOR: begin
          if (phase_cnt_reg == '0) begin
            state_reg         <= DONE;
            dispense_done_reg <= 1'b1;
            cups_served_reg   <= cups_next;
          end else begin
            flavor_valve_reg <= sel_reg;
            phase_cnt_reg    <= phase_cnt_reg - 1'b1;
          end
        end
        DONE: begin
          state_reg <= RELEASE;
        end
        // Hold here until the request drops so it cannot re-trigger a brew.
        RELEASE: begin
          if (!dispense) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        FAULT: begin
          if (!cup_empty) begin
            state_reg <= IDLE;
            fault_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          fault_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cup_drop      = cup_drop_reg;
  assign water_valve   = water_valve_reg;
  assign flavor_valve  = flavor_valve_reg;
  assign dispense_done = dispense_done_reg;
  assign busy          = busy_reg;
  assign fault         = fault_reg;
  assign sel_err       = sel_err_reg;
  assign cups_served   = cups_served_reg;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Bench for coffee_dispenser: directed brews with literal timing expectations,
// then randomized traffic compared every cycle against a timeline model.
module tb_coffee_dispenser;

  localparam int C  = 4;
  localparam int P  = 8;
  localparam int F  = 4;
  localparam int CW = 2;
  localparam int CUPS_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          dispense;
  logic [2:0]    coffee_select;
  logic          cup_empty;
  logic          cup_drop;
  logic          water_valve;
  logic [1:0]    flavor_valve;
  logic          dispense_done;
  logic          busy;
  logic          fault;
  logic          sel_err;
  logic [CW-1:0] cups_served;

  int n_total = 0;
  int n_pass  = 0;

  coffee_dispenser #(
    .CUP_CYCLES(C), .POUR_CYCLES(P), .FLAVOR_CYCLES(F), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .dispense(dispense), .coffee_select(coffee_select),
    .cup_empty(cup_empty), .cup_drop(cup_drop), .water_valve(water_valve),
    .flavor_valve(flavor_valve), .dispense_done(dispense_done), .busy(busy),
    .fault(fault), .sel_err(sel_err), .cups_served(cups_served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Timeline model: a brew is an elapsed-cycle count e since acceptance; each
  // actuator is on for a fixed window of e, and done lands right after the last window.
  // mode: 0 idle, 1 brewing, 2 waiting for request drop, 3 magazine fault
  int         m_mode = 0;
  int         m_e    = 0;
  int         m_cups = 0;
  logic [1:0] m_sel  = 2'b00;
  bit         m_selerr = 0;

  function automatic int brew_len();
    return C + P + ((m_sel == 2'b01) ? 0 : F);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_e = 0; m_cups = 0; m_selerr = 0;
    end else begin
      m_selerr = 0;
      case (m_mode)
        0: if (dispense) begin
             if (cup_empty) m_mode = 3;
             else if (coffee_select[1:0] == 2'b00) m_selerr = 1;
             else begin m_sel = coffee_select[1:0]; m_mode = 1; m_e = 1; end
           end
        1: if (m_e == brew_len() + 1) m_mode = 2;
           else begin
             m_e++;
             if (m_e == brew_len() + 1 && m_cups < CUPS_MAX) m_cups++;
           end
        2: if (!dispense) m_mode = 0;
        3: if (!cup_empty) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  // Single compare process: every cycle out of reset, mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      bit br;
      int exp_flav;
      br = (m_mode == 1);
      exp_flav = (br && m_sel != 2'b01 && m_e > C + P && m_e <= C + P + F) ? int'(m_sel) : 0;
      chk("cup_drop",      cup_drop,      br && m_e >= 1 && m_e <= C);
      chk("water_valve",   water_valve,   br && m_e > C && m_e <= C + P);
      chk("flavor_valve",  flavor_valve,  exp_flav);
      chk("dispense_done", dispense_done, br && m_e == brew_len() + 1);
      chk("busy",          busy,          m_mode == 1 || m_mode == 2);
      chk("fault",         fault,         m_mode == 3);
      chk("sel_err",       sel_err,       m_selerr);
      chk("cups_served",   cups_served,   m_cups);
      chk("actuator_excl", ((int'(cup_drop) + int'(water_valve) + int'(flavor_valve != 0)) > 1), 0);
    end
  end

  // Directed brew with literal timing pins; cycle k is the k-th cycle after the accepting edge.
  task automatic brew_directed(input logic [2:0] sel, input int flip_at, input logic [2:0] flip_sel,
                               input int drop_at, input int ncyc, input int exp_done,
                               input logic [1:0] exp_flav, input int exp_cups);
    int first_cup = 0, cup_n = 0, first_w = 0, w_n = 0, first_f = 0, f_n = 0;
    int done_c = 0, done_n = 0;
    logic [1:0] fv = 2'b00;
    @(negedge clk);
    dispense = 1'b1; coffee_select = sel;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (cup_drop) begin if (first_cup == 0) first_cup = c; cup_n++; end
      if (water_valve) begin if (first_w == 0) first_w = c; w_n++; end
      if (flavor_valve != 2'b00) begin if (first_f == 0) first_f = c; f_n++; fv = flavor_valve; end
      if (dispense_done) begin if (done_c == 0) done_c = c; done_n++; end
      if (c == flip_at) coffee_select = flip_sel;
      if (c == drop_at) dispense = 1'b0;
    end
    chk("d_first_cup", first_cup, 1);
    chk("d_cup_cycles", cup_n, C);
    chk("d_first_water", first_w, C + 1);
    chk("d_water_cycles", w_n, P);
    chk("d_first_flavor", first_f, (exp_flav != 2'b00) ? 13 : 0);
    chk("d_flavor_cycles", f_n, (exp_flav != 2'b00) ? F : 0);
    chk("d_flavor_value", fv, exp_flav);
    chk("d_done_cycle", done_c, exp_done);
    chk("d_done_pulses", done_n, 1);
    chk("d_cups_served", cups_served, exp_cups);
    chk("d_busy_after", busy, 0);
    $display("brew sel=%0d done_cycle=%0d cups=%0d", sel[1:0], done_c, cups_served);
  endtask

  initial begin
    int done_at;
    reset = 1'b0; dispense = 1'b0; coffee_select = 3'b000; cup_empty = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cups", cups_served, 0);
    chk("rst_fault", fault, 0);
    chk("rst_act", int'(cup_drop) + int'(water_valve) + int'(flavor_valve) + int'(dispense_done), 0);
    reset = 1'b1;
    @(negedge clk);

    brew_directed(3'b001, 0, 3'b000, 14, 16, 13, 2'b00, 1);
    brew_directed(3'b111, 6, 3'b001, 20, 22, 17, 2'b11, 2);

    // Empty magazine, then clear it with the request still held.
    @(negedge clk);
    cup_empty = 1'b1; dispense = 1'b1; coffee_select = 3'b010;
    repeat (3) @(negedge clk);
    chk("fault_flag", fault, 1);
    chk("fault_busy", busy, 0);
    chk("fault_act", int'(cup_drop) + int'(water_valve) + int'(flavor_valve), 0);
    cup_empty = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (dispense_done && done_at == 0) done_at = c;
      if (c == 19) dispense = 1'b0;
    end
    chk("fault_recover_done", done_at, 18);
    $display("fault recovery done_cycle=%0d", done_at);

    // Invalid select rejected each cycle, then a valid one is accepted.
    @(negedge clk);
    dispense = 1'b1; coffee_select = 3'b100;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("selerr_flag", sel_err, 1);
      chk("selerr_noact", int'(cup_drop) + int'(busy), 0);
    end
    coffee_select = 3'b010;
    repeat (2) @(negedge clk);
    chk("selerr_then_cup", cup_drop, 1);
    chk("selerr_cups", cups_served, 3);
    repeat (20) @(negedge clk);
    dispense = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during the water phase.
    dispense = 1'b1; coffee_select = 3'b001;
    repeat (8) @(negedge clk);
    @(posedge clk); #3;
    chk("pre_rst_water", water_valve, 1);
    reset = 1'b0;
    #1;
    chk("async_water", water_valve, 0);
    chk("async_busy", busy, 0);
    chk("async_cups", cups_served, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("restart_cup", cup_drop, 1);
    repeat (18) @(negedge clk);
    dispense = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Saturating counter with a 2-bit width.
    brew_directed(3'b001, 0, 3'b000, 14, 16, 13, 2'b00, 1);
    brew_directed(3'b001, 0, 3'b000, 14, 16, 13, 2'b00, 2);
    brew_directed(3'b001, 0, 3'b000, 14, 16, 13, 2'b00, 3);
    brew_directed(3'b001, 0, 3'b000, 14, 16, 13, 2'b00, 3);
    brew_directed(3'b001, 0, 3'b000, 14, 16, 13, 2'b00, 3);

    // Random traffic, occasional mid-cycle resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(499, 0) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      if (dispense) begin
        if ($urandom_range(99, 0) < 4) dispense = 1'b0;
      end else if ($urandom_range(99, 0) < 25) begin
        dispense = 1'b1;
      end
      if ($urandom_range(99, 0) < 20) coffee_select = 3'($urandom_range(7, 0));
      if ($urandom_range(99, 0) < 5) cup_empty = ~cup_empty;
      if (cup_empty && $urandom_range(99, 0) < 20) cup_empty = 1'b0;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/coffee_dispenser.md
Name: coffee_dispenser

Overview:
Dispense-side responder to the vend controller's dispense/coffee_select/dispense_done handshake. It accepts a held dispense request and latches the coffee selection. It then sequences the mechanism through timed phases: cup drop, water pour and, for flavoured coffee, flavour pour. When the cup is complete it returns a one-cycle dispense_done. It also tracks cup-supply faults, flags invalid selections and counts cups served.

Parameters:
CUP_CYCLES, 4, cycles cup_drop is held high (>=1)
POUR_CYCLES, 8, cycles water_valve is held high (>=1)
FLAVOR_CYCLES, 4, cycles flavor_valve is held non-zero (>=1)
CNT_W, 16, width of cups_served counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (0 = in reset); deassertion is synchronous to clk
dispense  input  1  request from vend controller; held high until dispense_done is seen
coffee_select  input  3  01 plain, 10 hazelnut, 11 coconut; 00 invalid; bit 2 ignored
cup_empty  input  1  cup magazine empty sensor, level
cup_drop  output  1  cup release actuator
water_valve  output  1  hot-water valve
flavor_valve  output  2  flavour valve select (10 hazelnut, 11 coconut, 00 closed)
dispense_done  output  1  one-cycle completion pulse to vend controller
busy  output  1  high in every state except IDLE and FAULT
fault  output  1  high while in FAULT
sel_err  output  1  high for a cycle in which a request was rejected for select 00
cups_served  output  CNT_W  completed cups, saturating

Behaviour:
- All outputs are registered. Under reset (reset=0), every output is 0, cups_served is 0 and the FSM is in IDLE; this applies immediately and asynchronously, including mid-brew.
- FSM states: IDLE, CUP, POUR, FLAVOR, DONE, RELEASE, FAULT. A phase counter is sized for max(CUP,POUR,FLAVOR)_CYCLES and reloads on every phase entry.
- IDLE: dispense is sampled every edge.
  - dispense=1 and cup_empty=1 -> FAULT. This takes priority over the select check.
  - dispense=1 and select[1:0]=00 -> stay in IDLE; sel_err=1 next cycle.
  - dispense=1 and valid select -> latch select[1:0]; go to CUP.
- CUP: cup_drop=1 for exactly CUP_CYCLES cycles, then POUR.
- POUR: water_valve=1 for exactly POUR_CYCLES cycles. Next state is DONE if the latched select is 01, otherwise FLAVOR.
- FLAVOR: flavor_valve = latched select for exactly FLAVOR_CYCLES cycles, then DONE.
- DONE: one cycle. dispense_done=1 and cups_served increments, saturating at all-ones. Then RELEASE.
- RELEASE: wait for dispense=0, then IDLE. This prevents the still-high request from re-triggering.
  - If dispense is already 0 on the first RELEASE cycle, return to IDLE at the next edge.
- FAULT: fault=1, no actuator active, no dispense_done. Exit to IDLE when cup_empty=0; a still-held request is then served normally.
- Actuator outputs are mutually exclusive; at most one of cup_drop, water_valve and flavor_valve is active in any cycle.
- Latency with defaults, request sampled at edge 0:
  - cup_drop high in cycles 1-4, water_valve in 5-12.
  - Plain: dispense_done in cycle 13.
  - Flavoured: flavor_valve in 13-16, dispense_done in cycle 17.
- After the request is accepted, changes on coffee_select and cup_empty are ignored until RELEASE.
- If dispense drops mid-brew, the brew still completes and dispense_done still pulses; RELEASE then exits on its first cycle.

Test Plan:
- Plain brew: reset, dispense=1, select=01 held until done -> cup_drop cycles 1-4, water 5-12, dispense_done single pulse at cycle 13, cups_served=1, flavor_valve stays 00; back in IDLE after dispense drops.
- Coconut brew: select=11 -> flavor_valve=11 cycles 13-16, done at 17. Flip select to 01 at cycle 6 -> flavour phase unchanged. Held dispense for 3 extra cycles -> only one done pulse and no second brew.
- Empty magazine: cup_empty=1, dispense=1, select=10 -> fault=1, busy=0, no actuators. Clear cup_empty -> IDLE, then full hazelnut brew with done at cycle 17 relative to re-acceptance.
- Invalid select: dispense=1, select=00 for 3 cycles -> sel_err=1 each following cycle, no actuators, cups_served unchanged. Then select=10 -> brew starts.
- Reset mid-operation: assert reset=0 during POUR -> water_valve, busy and cups_served go to 0 without waiting for a clock edge. After release with dispense=1, the brew restarts from CUP.
- Saturation: with CNT_W=2, complete 5 plain brews -> cups_served reads 1, 2, 3, 3, 3.
